// File: rtl/bnn_classifier.sv
// Binarised NN classifier: XNOR-popcount scoring against a weight ROM.
// Ports: clk, rst, img_in, write_enable -> weight_addr, weight_word,
//   busy, result_out, best_score, result_ready.
// Optional: define BNN_CLASSIFIER_REJECT_EN to report 8'hFF when the
//   winning score is below REJECT_THRESH.
module bnn_classifier #(
  parameter int IMG_BITS      = 784,
  parameter int NUM_CLASSES   = 10,
  parameter int CHUNK         = 16,
  parameter int REJECT_THRESH = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic [IMG_BITS-1:0] img_in,
  input  logic write_enable,
  output logic [$clog2(NUM_CLASSES*(IMG_BITS/CHUNK))-1:0] weight_addr,
  input  logic [CHUNK-1:0] weight_word,
  output logic busy,
  output logic [7:0] result_out,
  output logic [$clog2(IMG_BITS+1)-1:0] best_score,
  output logic result_ready
);

  localparam int NCHUNK = IMG_BITS / CHUNK;
  localparam int TOTAL  = NUM_CLASSES * NCHUNK;
  localparam int AW     = $clog2(TOTAL);
  localparam int SW     = $clog2(IMG_BITS + 1);
  localparam int CIW    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int CLW    = $clog2(NUM_CLASSES);

  localparam logic [AW-1:0]  LAST_A = AW'(TOTAL - 1);
  localparam logic [CIW-1:0] LAST_C = CIW'(NCHUNK - 1);

  if ((IMG_BITS % CHUNK) != 0) begin : g_chunk_chk
    $error("IMG_BITS must be a multiple of CHUNK");
  end
  if (NUM_CLASSES < 2 || NUM_CLASSES > 255) begin : g_cls_chk
    $error("NUM_CLASSES out of range");
  end
  if (REJECT_THRESH < 0) begin : g_thr_chk
    $error("REJECT_THRESH must be non-negative");
  end

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic [IMG_BITS-1:0] img_q;
  logic [AW-1:0]       f_addr;
  logic [CIW-1:0]      f_chunk;
  logic [CLW-1:0]      f_cls;

  // Tags for the ROM word arriving this cycle
  // (one cycle behind its address).
  logic           d_valid;
  logic           d_last;
  logic [CIW-1:0] d_chunk;
  logic [CLW-1:0] d_cls;

  logic [SW-1:0]  acc;
  logic [SW-1:0]  best_sc;
  logic [CLW-1:0] best_idx;

  logic [CHUNK-1:0] chunk_w;
  logic [CHUNK-1:0] match;
  logic [SW-1:0]    pop;
  logic [SW-1:0]    sum;
  logic             take;
  logic [SW-1:0]    win_sc;
  logic [CLW-1:0]   win_idx;

  wire start = (state == IDLE) && write_enable;
  wire f_end = (state == FETCH) && (f_addr == LAST_A);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (write_enable) state_n = FETCH;
      FETCH: if (f_addr == LAST_A) state_n = DRAIN;
      DRAIN: state_n = DONE;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      img_q   <= '0;
      f_addr  <= '0;
      f_chunk <= '0;
      f_cls   <= '0;
      d_valid <= 1'b0;
      d_last  <= 1'b0;
      d_chunk <= '0;
      d_cls   <= '0;
    end else begin
      if (start) img_q <= img_in;
      d_valid <= (state == FETCH);
      d_last  <= (f_chunk == LAST_C);
      d_chunk <= f_chunk;
      d_cls   <= f_cls;
      if (state != FETCH || f_end) begin
        f_addr  <= '0;
        f_chunk <= '0;
        f_cls   <= '0;
      end else begin
        f_addr <= f_addr + 1'b1;
        if (f_chunk == LAST_C) begin
          f_chunk <= '0;
          f_cls   <= f_cls + 1'b1;
        end else begin
          f_chunk <= f_chunk + 1'b1;
        end
      end
    end
  end

  assign chunk_w = img_q[d_chunk*CHUNK +: CHUNK];
  assign match   = ~(chunk_w ^ weight_word);

  always_comb begin
    pop = '0;
    for (int i = 0; i < CHUNK; i++) begin
      pop = pop + SW'(match[i]);
    end
  end

  assign sum = acc + pop;

  // Class 0 always seeds the running best; later classes
  // must strictly beat it, so ties keep the lower index.
  assign take    = (d_cls == '0) || (sum > best_sc);
  assign win_sc  = take ? sum : best_sc;
  assign win_idx = take ? d_cls : best_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      best_sc    <= '0;
      best_idx   <= '0;
      best_score <= '0;
      result_out <= '0;
    end else begin
      if (d_valid) begin
        if (d_last) begin
          acc      <= '0;
          best_sc  <= win_sc;
          best_idx <= win_idx;
        end else begin
          acc <= sum;
        end
      end
      // The last word lands in DRAIN; the result becomes
      // visible from the DONE cycle on.
      if (state == DRAIN) begin
        best_score <= win_sc;
`ifdef BNN_CLASSIFIER_REJECT_EN
        if (int'(win_sc) < REJECT_THRESH) result_out <= 8'hFF;
        else result_out <= 8'(win_idx);
`else
        result_out <= 8'(win_idx);
`endif
      end
    end
  end

  assign busy         = (state != IDLE);
  assign result_ready = (state == DONE);
  assign weight_addr  = (state == FETCH) ? f_addr : '0;

endmodule

// File: tb/tb_bnn_classifier.sv
// Self-checking bench for bnn_classifier with a pixel-level
// reference model and a synchronous weight ROM.
module tb_bnn_classifier;

  localparam int IMG = 784;
  localparam int NC  = 10;
  localparam int CH  = 16;
  localparam int NCH = IMG / CH;
  localparam int TOT = NC * NCH;
  localparam int AW  = $clog2(TOT);
  localparam int SW  = $clog2(IMG + 1);
  localparam int THR = 500;
  localparam int LAT = TOT + 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [IMG-1:0] img_in;
  logic           write_enable;
  logic [AW-1:0]  weight_addr;
  logic [CH-1:0]  weight_word;
  logic           busy;
  logic [7:0]     result_out;
  logic [SW-1:0]  best_score;
  logic           result_ready;

  logic [CH-1:0] rom [TOT];

  int n_checks = 0;
  int n_fail   = 0;

  bnn_classifier #(
    .IMG_BITS(IMG),
    .NUM_CLASSES(NC),
    .CHUNK(CH),
    .REJECT_THRESH(THR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .img_in(img_in),
    .write_enable(write_enable),
    .weight_addr(weight_addr),
    .weight_word(weight_word),
    .busy(busy),
    .result_out(result_out),
    .best_score(best_score),
    .result_ready(result_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) weight_word <= rom[weight_addr];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Score = number of pixels equal to their weight bit.
  function automatic void model(input logic [IMG-1:0] img,
                                output int cls,
                                output int sc);
    logic [CH-1:0] w;
    int s;
    sc  = -1;
    cls = 0;
    for (int c = 0; c < NC; c++) begin
      s = 0;
      for (int i = 0; i < IMG; i++) begin
        w = rom[c*NCH + i/CH];
        if (img[i] == w[i%CH]) s++;
      end
      if (s > sc) begin
        sc  = s;
        cls = c;
      end
    end
`ifdef BNN_CLASSIFIER_REJECT_EN
    if (sc < THR) cls = 255;
`endif
  endfunction

  function automatic logic [IMG-1:0] rand_img();
    logic [IMG-1:0] v;
    for (int i = 0; i < IMG; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  task automatic fill_rand();
    for (int i = 0; i < TOT; i++) rom[i] = CH'($urandom);
  endtask

  // Called at a negedge; drives the start and waits for the pulse.
  task automatic run(input logic [IMG-1:0] img,
                     input int flip_at,
                     input string tag,
                     output int r_cls,
                     output int r_sc,
                     output int r_lat);
    int e_cls, e_sc, cnt;
    bit got;
    model(img, e_cls, e_sc);
    img_in = img;
    write_enable = 1'b1;
    cnt = 0;
    got = 1'b0;
    while (!got && cnt < 2000) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (cnt == 1) begin
        write_enable = 1'b0;
        check({tag, ":busy"}, busy, 1);
        check({tag, ":addr0"}, weight_addr, 0);
      end
      if (cnt == 10) check({tag, ":addr9"}, weight_addr, 9);
      if (cnt == TOT + 1) check({tag, ":drain_addr"}, weight_addr, 0);
      if (flip_at > 0 && cnt == flip_at) begin
        write_enable = 1'b1;
        img_in = ~img;
      end
      if (flip_at > 0 && cnt == flip_at + 1) write_enable = 1'b0;
      if (result_ready) got = 1'b1;
    end
    check({tag, ":done"}, got, 1);
    check({tag, ":latency"}, cnt, LAT);
    check({tag, ":class"}, result_out, e_cls);
    check({tag, ":score"}, best_score, e_sc);
    r_cls = result_out;
    r_sc  = best_score;
    r_lat = cnt;
    @(posedge clk);
    @(negedge clk);
    check({tag, ":pulse_end"}, result_ready, 0);
    check({tag, ":idle"}, busy, 0);
    check({tag, ":hold"}, result_out, e_cls);
  endtask

  initial begin
    int cls, sc, lat, cls1, sc1, lat1;
    int e_cls, e_sc, cnt, pulses, p1, p2;
    logic [IMG-1:0] img;
    logic [CH-1:0]  w;

    rst = 1'b1;
    write_enable = 1'b0;
    img_in = '0;
    for (int i = 0; i < TOT; i++) rom[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst:busy", busy, 0);
    check("rst:ready", result_ready, 0);
    check("rst:addr", weight_addr, 0);
    check("rst:class", result_out, 0);
    check("rst:score", best_score, 0);

    // Class 3 alone matches an all-ones image.
    for (int i = 0; i < NCH; i++) rom[3*NCH + i] = '1;
    rst = 1'b0;
    run('1, 0, "winner", cls, sc, lat);
    check("winner:cls3", cls, 3);
    check("winner:784", sc, IMG);

    // Identical weights in every class.
    for (int k = 0; k < NCH; k++) begin
      w = CH'($urandom);
      for (int c = 0; c < NC; c++) rom[c*NCH + k] = w;
    end
    run(rand_img(), 0, "tie", cls, sc, lat);

    for (int t = 0; t < 3; t++) begin
      fill_rand();
      run(rand_img(), 0, "rand", cls, sc, lat);
    end

    // Restart attempt plus image change mid-run.
    fill_rand();
    img = rand_img();
    run(img, 0, "single", cls1, sc1, lat1);
    run(img, 50, "flip", cls, sc, lat);
    check("flip:same_cls", cls, cls1);
    check("flip:same_sc", sc, sc1);
    check("flip:same_lat", lat, lat1);

    // Back-to-back with write_enable held.
    fill_rand();
    img = rand_img();
    model(img, e_cls, e_sc);
    img_in = img;
    write_enable = 1'b1;
    cnt = 0;
    pulses = 0;
    p1 = 0;
    p2 = 0;
    while (pulses < 2 && cnt < 3000) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (result_ready) begin
        pulses++;
        check("b2b:class", result_out, e_cls);
        check("b2b:score", best_score, e_sc);
        if (pulses == 1) p1 = cnt;
        else begin
          p2 = cnt;
          write_enable = 1'b0;
        end
      end
    end
    check("b2b:pulses", pulses, 2);
    check("b2b:first", p1, LAT);
    check("b2b:gap", p2 - p1, LAT + 1);
    @(posedge clk);
    @(negedge clk);
    check("b2b:idle", busy, 0);

    // Reset in the middle of FETCH.
    fill_rand();
    img_in = rand_img();
    write_enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    write_enable = 1'b0;
    repeat (99) @(posedge clk);
    #2;
    check("mid:busy_pre", busy, 1);
    rst = 1'b1;
    #1;
    check("mid:busy", busy, 0);
    check("mid:ready", result_ready, 0);
    check("mid:addr", weight_addr, 0);
    check("mid:class", result_out, 0);
    check("mid:score", best_score, 0);
    repeat (3) begin
      @(negedge clk);
      check("mid:no_pulse", result_ready, 0);
    end
    rst = 1'b0;
    run(rand_img(), 0, "post_rst", cls, sc, lat);

    // Every class scores exactly half.
    for (int i = 0; i < TOT; i++) rom[i] = 16'h00FF;
    run('1, 0, "reject", cls, sc, lat);
    check("reject:392", sc, 392);
`ifdef BNN_CLASSIFIER_REJECT_EN
    check("reject:cls", cls, 255);
`else
    check("reject:cls", cls, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bnn_classifier.md
BNN_CLASSIFIER -- requirements
Module: bnn_classifier

Interface
REQ-001 SHALL have parameter IMG_BITS, default 784: binarised image length in bits.
REQ-002 SHALL have parameter NUM_CLASSES, default 10: number of output classes, range 2..255.
REQ-003 SHALL have parameter CHUNK, default 16: image bits processed per cycle; IMG_BITS mod CHUNK == 0 is required. NCHUNK = IMG_BITS/CHUNK.
REQ-004 SHALL have parameter REJECT_THRESH, default 0: minimum winning score (used only under REQ-030).
REQ-005 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port img_in, input, IMG_BITS: packed binarised image, bit i = pixel i.
REQ-008 SHALL have port write_enable, input, 1: start request.
REQ-009 SHALL have port weight_addr, output, $clog2(NUM_CLASSES*NCHUNK): weight ROM address = class*NCHUNK + chunk.
REQ-010 SHALL have port weight_word, input, CHUNK: ROM data, valid one cycle after its address.
REQ-011 SHALL have port busy, output, 1: high while an inference is in progress.
REQ-012 SHALL have port result_out, output, 8: winning class index.
REQ-013 SHALL have port best_score, output, $clog2(IMG_BITS+1): winning class match count.
REQ-014 SHALL have port result_ready, output, 1: one-cycle completion pulse.

Function
REQ-015 SHALL use FSM states IDLE, FETCH, DRAIN, DONE.
- IDLE->FETCH on write_enable.
- FETCH->DRAIN after the last address is issued.
- DRAIN->DONE after one cycle.
- DONE->IDLE after one cycle.
REQ-016 SHALL latch img_in on the start edge; img_in changes later in the run SHALL have no effect.
REQ-017 SHALL ignore write_enable whenever the state is not IDLE; no queuing.
REQ-018 SHALL issue addresses 0..NUM_CLASSES*NCHUNK-1 in ascending order, one per FETCH cycle; weight_addr SHALL read 0 outside FETCH.
REQ-019 SHALL compute each class score as the sum over chunks of popcount(XNOR(image chunk, weight_word)); chunk k covers image bits [k*CHUNK +: CHUNK].
REQ-020 SHALL size the per-class accumulator at $clog2(IMG_BITS+1) bits so it cannot overflow; the accumulator clears at each class boundary.
REQ-021 SHALL perform argmax on class completion: a class replaces the current best only if its score is strictly greater, so ties resolve to the lowest class index.
REQ-022 SHALL update result_out and best_score only on the DONE cycle and hold them until the next DONE or reset.
REQ-023 SHALL assert result_ready for exactly the DONE cycle, NUM_CLASSES*NCHUNK+2 edges after the start edge (492 with defaults).
REQ-024 SHALL drive busy high from the edge after start through the DONE cycle inclusive.
REQ-025 SHALL accept write_enable in the cycle immediately following DONE.

Reset
REQ-026 SHALL, while rst is high, force: state=IDLE, result_out=0, best_score=0, result_ready=0, busy=0, weight_addr=0, and clear all accumulators.
REQ-027 SHALL, on reset mid-inference, abandon the run: no result_ready pulse, and the prior result is lost.
REQ-028 SHALL, after rst deasserts, accept write_enable on the first rising edge.

Configuration
REQ-029 SHALL use macro BNN_CLASSIFIER_REJECT_EN to select the reject feature.
REQ-030 SHALL, with the macro defined, output result_out=8'hFF on DONE when the winning score < REJECT_THRESH; best_score still reports the winning score.
REQ-031 SHALL, with the macro undefined, never reject: REJECT_THRESH is ignored and there is no comparator logic.

Verification
REQ-032 SHALL cover reset: rst=1 mid-FETCH at cycle 100 -> all outputs at reset values within the same cycle, no result_ready; a fresh start then completes normally.
REQ-033 SHALL cover winner selection: img_in all ones, class 3 weights all ones, other classes all zeros -> result_out=3, best_score=784, result_ready exactly 492 cycles after start.
REQ-034 SHALL cover ties: all weights identical -> result_out=0.
REQ-035 SHALL cover ignored inputs: second write_enable at cycle 50 plus img_in flipped -> no restart; result and latency match the single-start run.
REQ-036 SHALL cover back-to-back runs: write_enable held high -> second run starts on the edge after DONE, 493 cycles between result_ready pulses.
REQ-037 SHALL cover reject: every class scores 392 with REJECT_THRESH=500 -> result_out=8'hFF when the macro is defined, result_out=0 when undefined; best_score=392 in both cases.
